// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants and FSM state type for the Viterbi ACS array
package viterbi_pkg;
    localparam int K           = 7;
    localparam int N_STATES    = 64;
    localparam int PM_W_DEF    = 8;
    localparam int INIT_PM_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } acs_state_t;
endpackage

// File: rtl/acs_select.sv
// acs_select: one add-compare-select for a single successor state.
// Build option ACS_MODULO_NORM_EN selects wrapping adds with a sign-of-difference
// compare; otherwise adds saturate, compare is unsigned, and norm subtracts half range.
module acs_select
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEF
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [1:0]      bm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_b,
    input  logic            norm,
    output logic [PM_W-1:0] pm_out,
    output logic            dec
);
`ifdef ACS_MODULO_NORM_EN
    logic [PM_W-1:0] cand_a, cand_b, diff;

    // Wrapping adds; b wins only when (b - a) is negative, so ties keep a
    always_comb begin
        cand_a = pm_a + {{(PM_W-2){1'b0}}, bm_a};
        cand_b = pm_b + {{(PM_W-2){1'b0}}, bm_b};
        diff   = cand_b - cand_a;
        dec    = diff[PM_W-1];
        pm_out = dec ? cand_b : cand_a;
    end
`else
    logic [PM_W:0]   sum_a, sum_b;
    logic [PM_W-1:0] cand_a, cand_b, sel;

    // Saturating adds, unsigned compare with ties to a, then optional half-range subtract
    always_comb begin
        sum_a  = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
        sum_b  = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
        cand_a = sum_a[PM_W] ? '1 : sum_a[PM_W-1:0];
        cand_b = sum_b[PM_W] ? '1 : sum_b[PM_W-1:0];
        dec    = cand_b < cand_a;
        sel    = dec ? cand_b : cand_a;
        pm_out = !norm ? sel : sel[PM_W-1] ? {1'b0, sel[PM_W-2:0]} : '0;
    end
`endif
endmodule

// File: rtl/acs_butterfly.sv
// acs_butterfly: radix-2 ACS butterfly owning states j and j+32 of the 64-state trellis.
// Arithmetic mode is chosen by ACS_MODULO_NORM_EN inside acs_select.
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int PM_W      = PM_W_DEF,
    parameter int STATE_IDX = 0,
    parameter int INIT_PM   = INIT_PM_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic            in_valid,
    input  logic            norm_sub,
    input  logic [PM_W-1:0] pm_pred0,
    input  logic [PM_W-1:0] pm_pred1,
    input  logic [1:0]      bm_0,
    input  logic [1:0]      bm_1,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            pm_msb_lo,
    output logic            pm_msb_hi,
    output logic            out_valid,
    output logic [15:0]     step_cnt
);
    localparam logic [PM_W-1:0] HI_INIT = PM_W'(INIT_PM);
    localparam logic [PM_W-1:0] LO_INIT = (STATE_IDX == 0) ? '0 : HI_INIT;

    acs_state_t      state_q, state_d;
    logic [PM_W-1:0] pm_lo_q, pm_lo_d, pm_hi_q, pm_hi_d, sel_lo, sel_hi;
    logic            dec_lo_q, dec_lo_d, dec_hi_q, dec_hi_d, sdec_lo, sdec_hi;
    logic            out_valid_q, out_valid_d, accept;
    logic [15:0]     step_cnt_q, step_cnt_d;

    acs_select #(.PM_W(PM_W)) u_lo (
        .pm_a(pm_pred0), .bm_a(bm_0), .pm_b(pm_pred1), .bm_b(bm_1),
        .norm(norm_sub), .pm_out(sel_lo), .dec(sdec_lo)
    );

    acs_select #(.PM_W(PM_W)) u_hi (
        .pm_a(pm_pred0), .bm_a(bm_1), .pm_b(pm_pred1), .bm_b(bm_0),
        .norm(norm_sub), .pm_out(sel_hi), .dec(sdec_hi)
    );

    // State and datapath registers; reset restores the init-load values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pm_lo_q     <= LO_INIT;
            pm_hi_q     <= HI_INIT;
            dec_lo_q    <= 1'b0;
            dec_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pm_lo_q     <= pm_lo_d;
            pm_hi_q     <= pm_hi_d;
            dec_lo_q    <= dec_lo_d;
            dec_hi_q    <= dec_hi_d;
            out_valid_q <= out_valid_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

    // Next state: init starts (or restarts) a frame from either state
    always_comb begin
        state_d = init ? RUN : state_q;
    end

    // Step acceptance and register updates; init overrides a coincident step
    always_comb begin
        accept      = (state_q == RUN) && in_valid && !init;
        pm_lo_d     = init ? LO_INIT : accept ? sel_lo  : pm_lo_q;
        pm_hi_d     = init ? HI_INIT : accept ? sel_hi  : pm_hi_q;
        dec_lo_d    = init ? 1'b0    : accept ? sdec_lo : dec_lo_q;
        dec_hi_d    = init ? 1'b0    : accept ? sdec_hi : dec_hi_q;
        out_valid_d = accept;
        step_cnt_d  = init ? '0 : (accept && step_cnt_q != 16'hFFFF) ? step_cnt_q + 16'd1 : step_cnt_q;
    end

    assign pm_lo     = pm_lo_q;
    assign pm_hi     = pm_hi_q;
    assign dec_lo    = dec_lo_q;
    assign dec_hi    = dec_hi_q;
    assign pm_msb_lo = pm_lo_q[PM_W-1];
    assign pm_msb_hi = pm_hi_q[PM_W-1];
    assign out_valid = out_valid_q;
    assign step_cnt  = step_cnt_q;
endmodule

// File: tb/tb_acs_butterfly.sv
// tb_acs_butterfly: directed vector bench for acs_butterfly (PM_W=8, STATE_IDX=0, INIT_PM=64)
module tb_acs_butterfly;
    logic       clk = 1'b0;
    logic       rst, init, in_valid, norm_sub;
    logic [7:0] pm_pred0, pm_pred1, pm_lo, pm_hi;
    logic [1:0] bm_0, bm_1;
    logic       dec_lo, dec_hi, pm_msb_lo, pm_msb_hi, out_valid;
    logic [15:0] step_cnt;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        logic [7:0] p0, p1;
        logic [1:0] b0, b1;
        logic       ns;
        logic [7:0] e_lo, e_hi;
        logic       e_dlo, e_dhi;
    } vec_t;

    acs_butterfly #(.PM_W(8), .STATE_IDX(0), .INIT_PM(64)) dut (
        .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .norm_sub(norm_sub),
        .pm_pred0(pm_pred0), .pm_pred1(pm_pred1), .bm_0(bm_0), .bm_1(bm_1),
        .pm_lo(pm_lo), .pm_hi(pm_hi), .dec_lo(dec_lo), .dec_hi(dec_hi),
        .pm_msb_lo(pm_msb_lo), .pm_msb_hi(pm_msb_hi), .out_valid(out_valid),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic [7:0] p0, input logic [7:0] p1, input logic [1:0] b0,
                         input logic [1:0] b1, input logic ns, input logic iv);
        pm_pred0 = p0; pm_pred1 = p1; bm_0 = b0; bm_1 = b1; norm_sub = ns; in_valid = iv;
    endtask

    task automatic chk_init_state(input string tag);
        chk({tag, "_pm_lo"}, 32'(pm_lo), 0);
        chk({tag, "_pm_hi"}, 32'(pm_hi), 64);
        chk({tag, "_dec"}, {30'd0, dec_hi, dec_lo}, 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_step_cnt"}, 32'(step_cnt), 0);
    endtask

    vec_t vecs[$];

    initial begin
`ifdef ACS_MODULO_NORM_EN
        vecs.push_back('{8'd250, 8'd4,   2'd0, 2'd0, 1'b1, 8'd250, 8'd250, 1'b0, 1'b0});
        vecs.push_back('{8'd10,  8'd20,  2'd1, 2'd2, 1'b1, 8'd11,  8'd12,  1'b0, 1'b0});
        vecs.push_back('{8'd255, 8'd0,   2'd3, 2'd3, 1'b0, 8'd2,   8'd2,   1'b0, 1'b0});
        vecs.push_back('{8'd30,  8'd10,  2'd3, 2'd0, 1'b0, 8'd10,  8'd13,  1'b1, 1'b1});
`else
        vecs.push_back('{8'd10,  8'd20,  2'd1, 2'd2, 1'b0, 8'd11,  8'd12,  1'b0, 1'b0});
        vecs.push_back('{8'd5,   8'd4,   2'd0, 2'd1, 1'b0, 8'd5,   8'd4,   1'b0, 1'b1});
        vecs.push_back('{8'd254, 8'd255, 2'd2, 2'd2, 1'b0, 8'd255, 8'd255, 1'b0, 1'b0});
        vecs.push_back('{8'd200, 8'd210, 2'd0, 2'd0, 1'b1, 8'd72,  8'd72,  1'b0, 1'b0});
        vecs.push_back('{8'd30,  8'd10,  2'd3, 2'd0, 1'b0, 8'd10,  8'd13,  1'b1, 1'b1});
        vecs.push_back('{8'd100, 8'd50,  2'd0, 2'd0, 1'b1, 8'd0,   8'd0,   1'b1, 1'b1});
        vecs.push_back('{8'd255, 8'd0,   2'd3, 2'd3, 1'b0, 8'd3,   8'd3,   1'b1, 1'b1});
        vecs.push_back('{8'd129, 8'd200, 2'd0, 2'd3, 1'b1, 8'd1,   8'd4,   1'b0, 1'b0});
`endif
        rst = 1'b1; init = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_init_state("reset");
        chk("reset_msb_hi", 32'(pm_msb_hi), 0);

        // Step offered while IDLE must be dropped
        drive(1, 1, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        chk_init_state("idle_step");

        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk_init_state("init");

        // Back-to-back steps
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].p0, vecs[i].p1, vecs[i].b0, vecs[i].b1, vecs[i].ns, 1'b1);
            @(negedge clk);
            chk($sformatf("v%0d_pm_lo", i), 32'(pm_lo), 32'(vecs[i].e_lo));
            chk($sformatf("v%0d_pm_hi", i), 32'(pm_hi), 32'(vecs[i].e_hi));
            chk($sformatf("v%0d_dec_lo", i), 32'(dec_lo), 32'(vecs[i].e_dlo));
            chk($sformatf("v%0d_dec_hi", i), 32'(dec_hi), 32'(vecs[i].e_dhi));
            chk($sformatf("v%0d_msb_lo", i), 32'(pm_msb_lo), 32'(vecs[i].e_lo[7]));
            chk($sformatf("v%0d_msb_hi", i), 32'(pm_msb_hi), 32'(vecs[i].e_hi[7]));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_step_cnt", i), 32'(step_cnt), i + 1);
        end

        // Idle gap: metrics and decisions hold, out_valid drops
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hold_out_valid", 32'(out_valid), 0);
        chk("hold_pm_lo", 32'(pm_lo), 32'(vecs[vecs.size()-1].e_lo));
        chk("hold_dec_lo", 32'(dec_lo), 32'(vecs[vecs.size()-1].e_dlo));
        chk("hold_step_cnt", 32'(step_cnt), vecs.size());

        // init together with a step: init wins
        drive(10, 20, 1, 2, 0, 1);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        chk_init_state("init_vs_step");

        drive(10, 20, 1, 2, 0, 1);
        @(negedge clk);
        chk("restart_step_cnt", 32'(step_cnt), 1);
        chk("restart_pm_lo", 32'(pm_lo), 11);

        // Reset mid-frame with a step in flight
        drive(5, 4, 0, 1, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_init_state("mid_reset");

        // After reset the FSM is IDLE again
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        chk_init_state("post_reset_idle");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
